// File: rtl/rv_pc_gen_if.sv
// Instruction-memory fetch port of the PC generator.
// Valid/ready: a fetch of imem_addr_o is transferred on a clock edge where
// imem_valid_o and imem_ready_i are both high (and the pipeline is not
// stalled); imem_valid_o never depends combinationally on imem_ready_i.
interface rv_pc_gen_if #(
    parameter int ADDR_WIDTH = 64
);
    logic                  imem_ready_i;
    logic                  imem_valid_o;
    logic [ADDR_WIDTH-1:0] imem_addr_o;
    logic [ADDR_WIDTH-1:0] imem_addr_next_o;

    // Driven by the PC generator.
    modport master (
        input  imem_ready_i,
        output imem_valid_o,
        output imem_addr_o,
        output imem_addr_next_o
    );

    // Driven by the instruction memory.
    modport slave (
        output imem_ready_i,
        input  imem_valid_o,
        input  imem_addr_o,
        input  imem_addr_next_o
    );
endinterface

// File: rtl/rv_pc_gen.sv
// Fetch program-counter generator.
// Issues the fetch address under valid/ready, steps by 4 (or 2 for compressed
// instructions when IALIGN==16), resolves branch/jal/jalr redirects, parks in
// FAULT on a misaligned taken target until a trap redirect, and counts
// accepted fetches. All address arithmetic wraps modulo 2^ADDR_WIDTH.
module rv_pc_gen #(
    parameter int                    ADDR_WIDTH   = 64,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
    parameter int                    IALIGN       = 32,
    parameter int                    CNT_WIDTH    = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    rv_pc_gen_if.master           imem,
    input  logic                  stall_i,
    input  logic                  instr_is_c_i,
    input  logic                  branch_en_i,
    input  logic                  b_type_instr_i,
    input  logic                  alu_zero_i,
    input  logic                  PCIncrSel_i,
    input  logic [ADDR_WIDTH-1:0] opr_a_i,
    input  logic [ADDR_WIDTH-1:0] imm_i,
    input  logic                  trap_i,
    input  logic [ADDR_WIDTH-1:0] trap_vec_i,
    output logic [ADDR_WIDTH-1:0] link_addr_o,
    output logic                  fault_o,
    output logic [ADDR_WIDTH-1:0] fault_addr_o,
    output logic [CNT_WIDTH-1:0]  fetch_cnt_o,
    output logic [1:0]            state_o
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] STEP_NORMAL = ADDR_WIDTH'(4);
    localparam logic [ADDR_WIDTH-1:0] STEP_RVC    = ADDR_WIDTH'(2);
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE     = CNT_WIDTH'(1);

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic [ADDR_WIDTH-1:0] pc_d;
    logic [ADDR_WIDTH-1:0] fault_addr_q;
    logic [CNT_WIDTH-1:0]  fetch_cnt_q;
    logic                  valid_q;
    logic                  fault_q;

    logic [ADDR_WIDTH-1:0] step;
    logic [ADDR_WIDTH-1:0] base;
    logic [ADDR_WIDTH-1:0] target_sum;
    logic [ADDR_WIDTH-1:0] target;
    logic                  taken;
    logic                  misaligned;
    logic                  accept;
    logic                  take_fault;

    // Sequential step size: compressed instructions only exist with IALIGN==16.
    always_comb begin
        step = STEP_NORMAL;
        if (IALIGN == 16 && instr_is_c_i) begin
            step = STEP_RVC;
        end
    end

    // Redirect target; jalr clears bit 0 of its computed address.
    always_comb begin
        base       = PCIncrSel_i ? opr_a_i : pc_q;
        target_sum = base + imm_i;
        target     = {target_sum[ADDR_WIDTH-1:1], target_sum[0] & ~PCIncrSel_i};
    end

    // Alignment check against the configured instruction alignment.
    always_comb begin
        misaligned = 1'b0;
        if (IALIGN == 16) begin
            misaligned = target[0];
        end else begin
            misaligned = |target[1:0];
        end
    end

    // Handshake qualification and control-transfer decision.
    always_comb begin
        taken      = branch_en_i & (alu_zero_i | ~b_type_instr_i);
        accept     = (state_q == ST_RUN) & valid_q & imem.imem_ready_i & ~stall_i;
        take_fault = accept & taken & misaligned;
    end

    // Next PC: trap, then hold (not accepted / faulting), then target, then step.
    always_comb begin
        pc_d = pc_q;
        if (trap_i) begin
            pc_d = trap_vec_i;
        end else if (!accept) begin
            pc_d = pc_q;
        end else if (taken) begin
            pc_d = misaligned ? pc_q : target;
        end else begin
            pc_d = pc_q + step;
        end
    end

    // Control FSM with PC, fault capture, fetch counter and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_BOOT;
            pc_q         <= RESET_VECTOR;
            fault_addr_q <= '0;
            fetch_cnt_q  <= '0;
            valid_q      <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            pc_q <= pc_d;
            if (trap_i) begin
                state_q <= ST_RUN;
                valid_q <= 1'b1;
                fault_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_BOOT: begin
                        state_q <= ST_RUN;
                        valid_q <= 1'b1;
                        fault_q <= 1'b0;
                    end
                    ST_RUN: begin
                        if (take_fault) begin
                            state_q      <= ST_FAULT;
                            valid_q      <= 1'b0;
                            fault_q      <= 1'b1;
                            fault_addr_q <= target;
                        end else if (accept) begin
                            fetch_cnt_q <= fetch_cnt_q + CNT_ONE;
                        end
                    end
                    ST_FAULT: begin
                        state_q <= ST_FAULT;
                        valid_q <= 1'b0;
                        fault_q <= 1'b1;
                    end
                    default: begin
                        state_q <= ST_BOOT;
                        valid_q <= 1'b0;
                        fault_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Output mapping.
    assign imem.imem_addr_o      = pc_q;
    assign imem.imem_valid_o     = valid_q;
    assign imem.imem_addr_next_o = pc_d;
    assign link_addr_o           = pc_q + step;
    assign fault_o               = fault_q;
    assign fault_addr_o          = fault_addr_q;
    assign fetch_cnt_o           = fetch_cnt_q;
    assign state_o               = state_q;

endmodule

// File: tb/tb_rv_pc_gen.sv
// Bench for rv_pc_gen: two instances (IALIGN 32 and 16) share one stimulus
// stream; a reference model predicts each post-edge output snapshot, which is
// queued and compared by an independent monitor.
module tb_rv_pc_gen;
    localparam int          AW = 64;
    localparam logic [63:0] RV = 64'h1000;

    // Clock and reset
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst = 1'b0;

    // Shared stimulus
    logic        ready = 1'b0, stall = 1'b0, is_c = 1'b0, br = 1'b0, bt = 1'b0;
    logic        zero = 1'b0, sel = 1'b0, trap = 1'b0;
    logic [63:0] opr_a = '0, imm = '0, tvec = '0;

    rv_pc_gen_if #(.ADDR_WIDTH(AW)) if32 ();
    rv_pc_gen_if #(.ADDR_WIDTH(AW)) if16 ();
    assign if32.imem_ready_i = ready;
    assign if16.imem_ready_i = ready;

    logic [63:0] link32, faddr32, cnt32, link16, faddr16, cnt16;
    logic        fault32, fault16;
    logic [1:0]  state32, state16;

    rv_pc_gen #(.ADDR_WIDTH(AW), .RESET_VECTOR(RV), .IALIGN(32), .CNT_WIDTH(64)) dut32 (
        .clk(clk), .rst(rst), .imem(if32.master), .stall_i(stall), .instr_is_c_i(is_c),
        .branch_en_i(br), .b_type_instr_i(bt), .alu_zero_i(zero), .PCIncrSel_i(sel),
        .opr_a_i(opr_a), .imm_i(imm), .trap_i(trap), .trap_vec_i(tvec),
        .link_addr_o(link32), .fault_o(fault32), .fault_addr_o(faddr32),
        .fetch_cnt_o(cnt32), .state_o(state32));

    rv_pc_gen #(.ADDR_WIDTH(AW), .RESET_VECTOR(RV), .IALIGN(16), .CNT_WIDTH(64)) dut16 (
        .clk(clk), .rst(rst), .imem(if16.master), .stall_i(stall), .instr_is_c_i(is_c),
        .branch_en_i(br), .b_type_instr_i(bt), .alu_zero_i(zero), .PCIncrSel_i(sel),
        .opr_a_i(opr_a), .imm_i(imm), .trap_i(trap), .trap_vec_i(tvec),
        .link_addr_o(link16), .fault_o(fault16), .fault_addr_o(faddr16),
        .fetch_cnt_o(cnt16), .state_o(state16));

    // Scoreboard
    typedef struct packed {
        logic [63:0] addr;
        logic        valid;
        logic        fault;
        logic [63:0] faddr;
        logic [63:0] cnt;
        logic [63:0] nxt;
        logic [63:0] link;
    } exp_t;
    exp_t exp_q32[$];
    exp_t exp_q16[$];
    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: booting / faulted flags plus architectural values.
    typedef struct {
        logic [63:0] pc;
        bit          boot;
        bit          flt;
        logic [63:0] faddr;
        logic [63:0] cnt;
    } model_t;
    model_t m32, m16;

    function automatic model_t m_reset();
        model_t r;
        r.pc = RV; r.boot = 1'b1; r.flt = 1'b0; r.faddr = '0; r.cnt = '0;
        return r;
    endfunction

    function automatic logic [63:0] m_step(int ia);
        return (ia == 16 && is_c) ? 64'd2 : 64'd4;
    endfunction

    function automatic logic [63:0] m_target(model_t s);
        logic [63:0] t;
        t = (sel ? opr_a : s.pc) + imm;
        if (sel) t[0] = 1'b0;
        return t;
    endfunction

    function automatic bit m_mis(logic [63:0] t, int ia);
        return (ia == 32) ? (t % 4 != 0) : (t % 2 != 0);
    endfunction

    function automatic bit m_taken();
        return br && (zero || !bt);
    endfunction

    function automatic logic [63:0] m_next_pc(model_t s, int ia);
        logic [63:0] t;
        if (trap) return tvec;
        if (s.boot || s.flt || !(ready && !stall)) return s.pc;
        t = m_target(s);
        if (m_taken()) return m_mis(t, ia) ? s.pc : t;
        return s.pc + m_step(ia);
    endfunction

    function automatic model_t m_adv(model_t s, int ia);
        model_t n;
        logic [63:0] t;
        n = s;
        n.pc = m_next_pc(s, ia);
        t = m_target(s);
        if (trap) begin
            n.boot = 1'b0; n.flt = 1'b0;
        end else if (s.boot) begin
            n.boot = 1'b0;
        end else if (!s.flt && ready && !stall) begin
            if (m_taken() && m_mis(t, ia)) begin
                n.flt = 1'b1; n.faddr = t;
            end else begin
                n.cnt = s.cnt + 1;
            end
        end
        return n;
    endfunction

    function automatic exp_t snap(model_t m, int ia);
        exp_t e;
        e.addr = m.pc; e.valid = !m.boot && !m.flt; e.fault = m.flt;
        e.faddr = m.faddr; e.cnt = m.cnt;
        e.nxt = m_next_pc(m, ia); e.link = m.pc + m_step(ia);
        return e;
    endfunction

    // Driver tasks
    task automatic idle();
        ready = 1'b0; stall = 1'b0; is_c = 1'b0; br = 1'b0; bt = 1'b0;
        zero = 1'b0; sel = 1'b0; trap = 1'b0; opr_a = '0; imm = '0; tvec = '0;
    endtask

    task automatic tick();
        m32 = m_adv(m32, 32);
        m16 = m_adv(m16, 16);
        exp_q32.push_back(snap(m32, 32));
        exp_q16.push_back(snap(m16, 16));
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        m32 = m_reset();
        m16 = m_reset();
        exp_q32.push_back(snap(m32, 32));
        exp_q16.push_back(snap(m16, 16));
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic trap_to(input logic [63:0] v);
        idle(); trap = 1'b1; tvec = v;
        tick();
        trap = 1'b0;
    endtask

    // Monitor: compare each post-edge snapshot against the oldest prediction.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q32.size() > 0) begin
            e = exp_q32.pop_front();
            chk("addr32", if32.imem_addr_o, e.addr);
            chk("valid32", 64'(if32.imem_valid_o), 64'(e.valid));
            chk("fault32", 64'(fault32), 64'(e.fault));
            chk("faddr32", faddr32, e.faddr);
            chk("cnt32", cnt32, e.cnt);
            chk("next32", if32.imem_addr_next_o, e.nxt);
            chk("link32", link32, e.link);
        end
        if (exp_q16.size() > 0) begin
            e = exp_q16.pop_front();
            chk("addr16", if16.imem_addr_o, e.addr);
            chk("valid16", 64'(if16.imem_valid_o), 64'(e.valid));
            chk("fault16", 64'(fault16), 64'(e.fault));
            chk("faddr16", faddr16, e.faddr);
            chk("cnt16", cnt16, e.cnt);
            chk("next16", if16.imem_addr_next_o, e.nxt);
            chk("link16", link16, e.link);
        end
    end

    // Reset must act without waiting for a clock edge.
    always @(posedge rst) begin
        #1;
        chk("async_rst_addr32", if32.imem_addr_o, RV);
        chk("async_rst_valid32", 64'(if32.imem_valid_o), 64'd0);
        chk("async_rst_fault32", 64'(fault32), 64'd0);
        chk("async_rst_cnt32", cnt32, 64'd0);
        chk("async_rst_faddr32", faddr32, 64'd0);
        chk("async_rst_addr16", if16.imem_addr_o, RV);
        chk("async_rst_cnt16", cnt16, 64'd0);
    end

    // Watchdog
    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // Stimulus
    initial begin
        int r;
        idle();
        @(negedge clk);
        do_reset();
        // BOOT cycle, then two accepted fetches
        idle(); tick();
        ready = 1'b1; tick(); tick();
        // stall holds the PC and the count
        trap_to(64'h2000);
        idle(); ready = 1'b1; stall = 1'b1; tick(); tick(); tick();
        stall = 1'b0; tick();
        // B-type taken / not taken
        trap_to(64'h3000);
        idle(); ready = 1'b1; br = 1'b1; bt = 1'b1; zero = 1'b1; imm = 64'hFFFF_FFFF_FFFF_FFF8; tick();
        trap_to(64'h3000);
        idle(); ready = 1'b1; br = 1'b1; bt = 1'b1; zero = 1'b0; imm = 64'hFFFF_FFFF_FFFF_FFF8; tick();
        // jalr clears bit 0
        trap_to(64'h3000);
        idle(); ready = 1'b1; br = 1'b1; sel = 1'b1; opr_a = 64'h5001; imm = 64'd4; tick();
        // misaligned jal: faults only with 32-bit alignment
        trap_to(64'h4000);
        idle(); ready = 1'b1; br = 1'b1; imm = 64'd6; tick();
        idle(); ready = 1'b1; tick();
        trap_to(64'h8000);
        idle(); ready = 1'b1; tick();
        // compressed step
        trap_to(64'h100);
        idle(); ready = 1'b1; is_c = 1'b1; tick();
        // wrap at the top of the address space
        trap_to(64'hFFFF_FFFF_FFFF_FFFC);
        idle(); ready = 1'b1; tick();
        // trap wins over an accepted taken branch
        idle(); ready = 1'b1; br = 1'b1; imm = 64'h40; trap = 1'b1; tvec = 64'h9000; tick();
        // fault pending, then reset mid-operation
        idle(); ready = 1'b1; br = 1'b1; imm = 64'd2; tick();
        idle(); tick();
        do_reset();
        idle(); tick();
        ready = 1'b1; tick();
        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end
            ready = ($urandom_range(0, 3) != 0);
            stall = ($urandom_range(0, 3) == 0);
            is_c  = 1'($urandom_range(0, 1));
            br    = ($urandom_range(0, 9) < 3);
            bt    = 1'($urandom_range(0, 1));
            zero  = 1'($urandom_range(0, 1));
            sel   = ($urandom_range(0, 9) < 3);
            opr_a = {$urandom(), $urandom()};
            r     = int'($urandom_range(0, 64)) - 32;
            imm   = {{32{r[31]}}, r};
            trap  = ($urandom_range(0, 11) == 0);
            tvec  = {$urandom(), $urandom()} & ~64'h3;
            tick();
        end
        idle();
        @(posedge clk);
        #2;
        chk("queue32_drained", 64'(exp_q32.size()), 64'd0);
        chk("queue16_drained", 64'(exp_q16.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
